stream_demux_1to4: RTL and testbench
====================================

Name: stream_demux_1to4

Overview:
- Registered 1-to-4 demultiplexer for valid/ready streams; the receive-side counterpart of the team's 4:1 gate-level selector.
- Routes each input packet, as a sequence of beats terminated by in_last, to one of four output lanes.
- Lane choice comes from the in_sel field or from an internal round-robin pointer.
- Holds the chosen lane for a whole packet.
- Each lane has a one-deep output register.
- Sits between a shared producer and four independent consumers.

Parameters:
- W, 8, data width per beat.
- NLANE, 4, number of output lanes; fixed at 4 (sel width 2); other values are unsupported.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  W  input beat payload.
- in_last  in  1  final beat of packet.
- in_sel  in  2  destination lane; sampled only on the first beat of a packet.
- rr_en  in  1  1 = ignore in_sel and use the round-robin pointer; sampled only on the first beat.
- out_valid  out  4  per-lane valid.
- out_ready  in  4  per-lane ready.
- out_data  out  4*W  lane k occupies bits [k*W +: W].
- out_last  out  4  per-lane last flag.
- busy  out  1  1 while a packet is locked (mid-packet).
- cur_lane  out  2  lane currently locked, or the lane the next packet head will target.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_last=0.
  - busy=0, state=IDLE, rr_ptr=0, lock_lane=0, cur_lane=0.
  - in_ready=1 after reset, because all lane registers are empty.
- Target lane:
  - IDLE: tgt = rr_en ? rr_ptr : in_sel.
  - LOCKED: tgt = lock_lane.
  - cur_lane = tgt in both states.
- Lane register k is "free" when !out_valid[k] || out_ready[k] (same-cycle drain allowed).
- in_ready = free(tgt).
  - in_ready is combinational from state, rr_ptr, in_sel, rr_en and out_valid/out_ready.
  - It does not depend on in_valid.
- On accept:
  - Lane tgt loads in_data/in_last and sets out_valid[tgt]=1 at the next edge.
  - Latency is 1 cycle; throughput is 1 beat/cycle per lane while the consumer keeps ready high.
- A lane register whose beat is consumed (out_valid && out_ready) and not reloaded clears out_valid the next cycle.
  - out_data/out_last hold their last value.
- Output stability: while out_valid[k]=1 && out_ready[k]=0, out_data/out_last[k] hold constant.
- FSM:
  - IDLE, accept, in_last=0 -> LOCKED; lock_lane=tgt; busy=1.
  - IDLE, accept, in_last=1 -> stay IDLE (single-beat packet).
  - LOCKED, accept, in_last=1 -> IDLE; busy=0.
  - LOCKED, accept, in_last=0 -> stay LOCKED.
  - No accept -> hold state.
- Round-robin pointer:
  - rr_ptr advances (rr_ptr+1 mod 4, wraps 3->0) only when a packet ends (accepted beat with in_last=1) and that packet's head was taken with rr_en=1.
  - Store a latched rr_mode bit at the head beat to track this.
  - Packets routed by in_sel do not move rr_ptr.
- Mid-packet changes to in_sel or rr_en are ignored.
- Blocked lane: if the target lane is full and its consumer is not ready, in_ready=0.
  - Other lanes keep draining independently.
  - No reordering and no lane switching.
- Simultaneous events: drain and reload of the same lane in one cycle give a back-to-back beat, with out_valid staying 1.
- Reset mid-packet: all state is lost immediately, including lane contents and the lock.
  - After release, the next accepted beat is treated as a packet head.

Decomposition:
- Shared package stream_demux_pkg:
  - state enum {IDLE, LOCKED}.
  - LANE_W=2, NLANE=4.
- Sub-module demux_lane_reg: one-deep valid/ready output register with data+last, instantiated 4 times.
  - Ports: clk, rst_n, load, d_data, d_last, out_valid, out_ready, out_data, out_last, free.
- Top keeps the FSM, rr_ptr, lock_lane and the in_ready mux.

Test Plan:
- Reset and idle: reset with all out_ready=1 -> out_valid=0000, busy=0, in_ready=1, cur_lane=0.
- Fixed select: rr_en=0, in_sel=2, 3-beat packet A0,A1,A2 (last on A2), with in_sel changed to 1 after the head -> all beats on lane 2 one cycle after each accept; busy=1 for the cycles after A0 and A1 accept; rr_ptr stays 0.
- Round-robin wrap: rr_en=1, five single-beat packets 0x10..0x14 -> lanes 0,1,2,3,0 in order; rr_ptr=1 at the end.
- Backpressure: lane 1 out_ready=0, stream a 2-beat packet to lane 1 -> first beat held on out_data[15:8] stable; in_ready=0 on the second beat until out_ready[1]=1, then the second beat delivered next cycle; lane 3 traffic between packets unaffected.
- Full throughput: lane 0 out_ready=1, 8-beat packet in back-to-back cycles -> in_ready stays 1 and out_valid[0] stays high for 8 consecutive cycles.
- Reset mid-packet: assert rst_n=0 after beat 2 of a 4-beat packet on lane 3 -> out_valid=0000 and busy=0 immediately; after release, the next beat with rr_en=0, in_sel=0 goes to lane 0.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared definitions for the 1-to-4 valid/ready stream demultiplexer.
// Holds the packet-lock state enum, lane geometry constants and the
// round-robin pointer helper used by the top level.
package stream_demux_pkg;

    localparam int LANE_W = 2;
    localparam int NLANE  = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Next round-robin lane; wraps 3 -> 0 through natural 2-bit overflow.
    function automatic logic [LANE_W-1:0] rr_next(input logic [LANE_W-1:0] ptr);
        return ptr + 2'd1;
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-deep valid/ready output register for a single demux lane.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   load               capture d_data/d_last this edge (caller guarantees free)
//   d_data, d_last     beat payload and end-of-packet flag to capture
//   out_valid          lane holds an unconsumed beat
//   out_ready          consumer accepts the held beat this cycle
//   out_data, out_last held beat payload and last flag (stable while stalled)
//   free               register can accept a new beat this cycle
module demux_lane_reg
    import stream_demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d_data,
    input  logic         d_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         free
);

    logic         valid_r;
    logic [W-1:0] data_r;
    logic         last_r;

    // Empty, or emptying this cycle: a same-cycle drain lets a reload land back-to-back.
    assign free = !valid_r || out_ready;

    // Beat holding register; payload only changes on load so it stays stable under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {W{1'b0}};
            last_r  <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= d_data;
            last_r  <= d_last;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign out_last  = last_r;

endmodule

// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 demultiplexer for valid/ready packet streams.
// A packet (beats up to and including in_last) is routed whole to one lane,
// chosen at the head beat from in_sel or from an internal round-robin pointer.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          input handshake; in_ready depends only on the target lane
//   in_data, in_last           beat payload, end-of-packet flag
//   in_sel, rr_en              lane select / round-robin enable, used on head beats only
//   out_valid/out_ready [4]    per-lane handshake
//   out_data [4*W]             lane k at bits [k*W +: W]
//   out_last [4]               per-lane last flag
//   busy                       a packet is locked to a lane
//   cur_lane                   locked lane, or the lane the next head would take
module stream_demux_1to4
    import stream_demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    input  logic [1:0]       in_sel,
    input  logic             rr_en,
    output logic [NLANE-1:0] out_valid,
    input  logic [NLANE-1:0] out_ready,
    output logic [NLANE*W-1:0] out_data,
    output logic [NLANE-1:0] out_last,
    output logic             busy,
    output logic [1:0]       cur_lane
);

    state_t              state_r, state_nxt_s;
    logic [LANE_W-1:0]   lock_lane_r, lock_lane_nxt_s;
    logic [LANE_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
    logic                rr_mode_r, rr_mode_nxt_s;
    logic [LANE_W-1:0]   tgt_s;
    logic                head_rr_s;
    logic                accept_s;
    logic [NLANE-1:0]    free_s;
    logic [NLANE-1:0]    load_s;

    // Target lane and whether the current packet was routed round-robin.
    always_comb begin
        tgt_s     = lock_lane_r;
        head_rr_s = rr_mode_r;
        if (state_r == LOCKED) begin
            tgt_s     = lock_lane_r;
            head_rr_s = rr_mode_r;
        end else if (rr_en) begin
            tgt_s     = rr_ptr_r;
            head_rr_s = 1'b1;
        end else begin
            tgt_s     = in_sel;
            head_rr_s = 1'b0;
        end
    end

    assign in_ready = free_s[tgt_s];
    assign accept_s = in_valid && in_ready;
    assign cur_lane = tgt_s;
    assign busy     = (state_r == LOCKED);

    // Steer the accepted beat into exactly one lane register.
    always_comb begin
        load_s = {NLANE{1'b0}};
        for (int k = 0; k < NLANE; k++) begin
            load_s[k] = accept_s && (tgt_s == LANE_W'(k));
        end
    end

    // Packet lock FSM and round-robin bookkeeping.
    always_comb begin
        state_nxt_s     = state_r;
        lock_lane_nxt_s = lock_lane_r;
        rr_mode_nxt_s   = rr_mode_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        case (state_r)
            IDLE: begin
                if (accept_s && !in_last) begin
                    state_nxt_s     = LOCKED;
                    lock_lane_nxt_s = tgt_s;
                    rr_mode_nxt_s   = rr_en;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCKED: begin
                if (accept_s && in_last) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        // Only packets whose head used the pointer move it, and only once they end.
        if (accept_s && in_last && head_rr_s) begin
            rr_ptr_nxt_s = rr_next(rr_ptr_r);
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            lock_lane_r <= 2'd0;
            rr_mode_r   <= 1'b0;
            rr_ptr_r    <= 2'd0;
        end else begin
            state_r     <= state_nxt_s;
            lock_lane_r <= lock_lane_nxt_s;
            rr_mode_r   <= rr_mode_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
        end
    end

    for (genvar k = 0; k < NLANE; k++) begin : g_lane
        demux_lane_reg #(.W(W)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load_s[k]),
            .d_data    (in_data),
            .d_last    (in_last),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_data  (out_data[k*W +: W]),
            .out_last  (out_last[k]),
            .free      (free_s[k])
        );
    end

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Self-checking bench for stream_demux_1to4: directed vector table,
// hand-written throughput and mid-packet reset sequences, then random
// traffic against a lane-occupancy reference model.
module tb_stream_demux_1to4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic [1:0]  in_sel;
    logic        rr_en;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_last;
    logic        busy;
    logic [1:0]  cur_lane;

    int n_pass;
    int n_tot;

    stream_demux_1to4 #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_sel    (in_sel),
        .rr_en     (rr_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .cur_lane  (cur_lane)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic [1:0]  sel;
        logic        rr;
        logic [3:0]  ordy;
        logic        e_rdy;
        logic [3:0]  e_ov;
        logic        e_busy;
        logic [1:0]  e_cur;
        logic [31:0] e_od;
    } vec_t;

    vec_t tbl [21];

    // reference model state
    logic       m_locked;
    logic [1:0] m_lane;
    logic [1:0] m_rr;
    logic       m_rrm;
    logic [3:0] m_v;
    logic [3:0] m_l;
    logic [7:0] m_d [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l,
                         input logic [1:0] s, input logic r, input logic [3:0] o);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        in_sel    = s;
        rr_en     = r;
        out_ready = o;
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_locked = 1'b0;
        m_lane   = 2'd0;
        m_rr     = 2'd0;
        m_rrm    = 1'b0;
        m_v      = 4'h0;
        m_l      = 4'h0;
        for (int k = 0; k < 4; k++) m_d[k] = 8'h00;
    endtask

    initial begin
        logic [1:0]  tgt;
        logic        e_rdy;
        logic        acc;
        logic        head_rr;
        logic [3:0]  ordy;
        n_pass = 0;
        n_tot  = 0;

        //             v     d      l     sel   rr    ordy   rdy   ov    busy  cur   od
        tbl[0]  = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 32'h00000000};
        tbl[1]  = '{1'b1, 8'hA0, 1'b0, 2'd2, 1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd2, 32'h00000000};
        tbl[2]  = '{1'b1, 8'hA1, 1'b0, 2'd1, 1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 32'h00A00000};
        tbl[3]  = '{1'b1, 8'hA2, 1'b1, 2'd1, 1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 32'h00A10000};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 4'hF, 1'b1, 4'h4, 1'b0, 2'd1, 32'h00A20000};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 2'd2, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 32'h00A20000};
        tbl[6]  = '{1'b1, 8'h10, 1'b1, 2'd3, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 32'h00A20000};
        tbl[7]  = '{1'b1, 8'h11, 1'b1, 2'd3, 1'b1, 4'hF, 1'b1, 4'h1, 1'b0, 2'd1, 32'h00A20010};
        tbl[8]  = '{1'b1, 8'h12, 1'b1, 2'd3, 1'b1, 4'hF, 1'b1, 4'h2, 1'b0, 2'd2, 32'h00A21110};
        tbl[9]  = '{1'b1, 8'h13, 1'b1, 2'd0, 1'b1, 4'hF, 1'b1, 4'h4, 1'b0, 2'd3, 32'h00121110};
        tbl[10] = '{1'b1, 8'h14, 1'b1, 2'd1, 1'b1, 4'hF, 1'b1, 4'h8, 1'b0, 2'd0, 32'h13121110};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 2'd2, 1'b1, 4'hF, 1'b1, 4'h1, 1'b0, 2'd1, 32'h13121114};
        tbl[12] = '{1'b1, 8'hB0, 1'b0, 2'd1, 1'b0, 4'hD, 1'b1, 4'h0, 1'b0, 2'd1, 32'h13121114};
        tbl[13] = '{1'b1, 8'hB1, 1'b1, 2'd0, 1'b0, 4'hD, 1'b0, 4'h2, 1'b1, 2'd1, 32'h1312B014};
        tbl[14] = '{1'b1, 8'hB1, 1'b1, 2'd0, 1'b0, 4'hD, 1'b0, 4'h2, 1'b1, 2'd1, 32'h1312B014};
        tbl[15] = '{1'b1, 8'hB1, 1'b1, 2'd0, 1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 32'h1312B014};
        tbl[16] = '{1'b1, 8'hC3, 1'b1, 2'd3, 1'b0, 4'hD, 1'b1, 4'h2, 1'b0, 2'd3, 32'h1312B114};
        tbl[17] = '{1'b1, 8'hC4, 1'b1, 2'd3, 1'b0, 4'hD, 1'b1, 4'hA, 1'b0, 2'd3, 32'hC312B114};
        tbl[18] = '{1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 4'hD, 1'b0, 4'hA, 1'b0, 2'd1, 32'hC412B114};
        tbl[19] = '{1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 4'hF, 1'b1, 4'h2, 1'b0, 2'd1, 32'hC412B114};
        tbl[20] = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 32'hC412B114};

        do_reset();

        // directed table: fixed select, round-robin wrap, backpressure
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].sel, tbl[i].rr, tbl[i].ordy);
            #4;
            chk($sformatf("tbl%0d in_ready", i),  32'(in_ready),  32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("tbl%0d busy", i),      32'(busy),      32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d cur_lane", i),  32'(cur_lane),  32'(tbl[i].e_cur));
            chk($sformatf("tbl%0d out_data", i),  out_data,       tbl[i].e_od);
            step();
        end

        // full throughput: 8-beat packet to lane 0 back-to-back
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'h50 + i), (i == 7), 2'd0, 1'b0, 4'hF);
            #4;
            chk($sformatf("tput%0d in_ready", i), 32'(in_ready), 32'd1);
            chk($sformatf("tput%0d busy", i), 32'(busy), 32'(i > 0));
            if (i > 0) begin
                chk($sformatf("tput%0d lane0 valid", i), 32'(out_valid[0]), 32'd1);
                chk($sformatf("tput%0d lane0 data", i), 32'(out_data[7:0]), 32'(8'h50 + i - 1));
            end
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 4'hF);
        #4;
        chk("tput end lane0 valid", 32'(out_valid[0]), 32'd1);
        chk("tput end lane0 data", 32'(out_data[7:0]), 32'h57);
        chk("tput end lane0 last", 32'(out_last[0]), 32'd1);
        chk("tput end busy", 32'(busy), 32'd0);
        step();

        // reset mid-packet on lane 3
        drive(1'b1, 8'hD0, 1'b0, 2'd3, 1'b0, 4'h0);
        step();
        drive(1'b1, 8'hD1, 1'b0, 2'd3, 1'b0, 4'h7);
        step();
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 4'h7);
        #1;
        chk("prerst lane3 valid", 32'(out_valid[3]), 32'd1);
        chk("prerst busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst out_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        drive(1'b1, 8'hE2, 1'b0, 2'd0, 1'b0, 4'h7);
        #4;
        chk("postrst cur_lane", 32'(cur_lane), 32'd0);
        chk("postrst in_ready", 32'(in_ready), 32'd1);
        step();
        drive(1'b1, 8'hE3, 1'b1, 2'd0, 1'b0, 4'hF);
        #4;
        chk("postrst out_valid", 32'(out_valid), 32'h1);
        chk("postrst lane0 data", 32'(out_data[7:0]), 32'hE2);
        chk("postrst busy", 32'(busy), 32'd1);
        step();

        // random traffic against the reference model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 4; k++) ordy[k] = ($urandom_range(0, 9) < 7);
            drive(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
                  2'($urandom), 1'($urandom), ordy);
            #4;
            if (m_locked) tgt = m_lane;
            else if (rr_en) tgt = m_rr;
            else tgt = in_sel;
            e_rdy = !m_v[tgt] || out_ready[tgt];
            chk("rnd in_ready", 32'(in_ready), 32'(e_rdy));
            chk("rnd cur_lane", 32'(cur_lane), 32'(tgt));
            chk("rnd busy", 32'(busy), 32'(m_locked));
            chk("rnd out_valid", 32'(out_valid), 32'(m_v));
            chk("rnd out_data", out_data, {m_d[3], m_d[2], m_d[1], m_d[0]});
            chk("rnd out_last", 32'(out_last), 32'(m_l));
            // model update for this edge
            acc     = in_valid && e_rdy;
            head_rr = m_locked ? m_rrm : rr_en;
            for (int k = 0; k < 4; k++) begin
                if (acc && (tgt == 2'(k))) begin
                    m_v[k] = 1'b1;
                    m_d[k] = in_data;
                    m_l[k] = in_last;
                end else if (out_ready[k]) begin
                    m_v[k] = 1'b0;
                end
            end
            if (acc && in_last && head_rr) m_rr = m_rr + 2'd1;
            if (acc && !m_locked && !in_last) begin
                m_locked = 1'b1;
                m_lane   = tgt;
                m_rrm    = rr_en;
            end else if (acc && m_locked && in_last) begin
                m_locked = 1'b0;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
